// File: rtl/v810_bus_target_pkg.sv
// v810_bus_pkg: types shared by the V810 bus target and a future bus monitor.
//   CNT_W       wait-state counter width
//   tgt_state_e target cycle state
//   bus_cyc_t   one latched bus cycle (word address, active-high BE, RW, ST)
package v810_bus_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      TS_IDLE,
      TS_WAIT,
      TS_ACC
   } tgt_state_e;

   typedef struct packed {
      logic [29:0] addr;
      logic [3:0]  be;
      logic        rw;
      logic [1:0]  st;
   } bus_cyc_t;

endpackage

// File: rtl/v810_bus_target_if.sv
// v810_bus_if: V810 external bus as seen between the CPU and its targets.
//   master : CPU side, drives address/control/write data, samples D_O, READYn, SZRQn
//   slave  : target side, the reverse
interface v810_bus_if;
   import v810_bus_pkg::*;

   logic [31:0] A;
   logic [31:0] D_I;
   logic [31:0] D_O;
   logic [3:0]  BEn;
   logic [1:0]  ST;
   logic        DAn;
   logic        MRQn;
   logic        RW;
   logic        BCYSTn;
   logic        READYn;
   logic        SZRQn;

   modport master (
      output A, D_I, BEn, ST, DAn, MRQn, RW, BCYSTn,
      input  D_O, READYn, SZRQn
   );

   modport slave (
      input  A, D_I, BEn, ST, DAn, MRQn, RW, BCYSTn,
      output D_O, READYn, SZRQn
   );

endinterface

// File: rtl/v810_bus_target_lanes.sv
// v810_tgt_lanes: data lane steering between the CPU bus and the 32-bit memory port.
//   BUS16   1 = 16-bit device: write data duplicated, read half replicated
//   ready   cycle completing; read data is driven only then
//   hi      upper halfword selected (latched BE[1:0] both off)
//   d_i     CPU write data         -> mem_wd
//   mem_rd  memory read data       -> d_o
module v810_tgt_lanes #(
   parameter bit BUS16 = 1'b0
) (
   input  logic        ready,
   input  logic        hi,
   input  logic [31:0] d_i,
   input  logic [31:0] mem_rd,
   output logic [31:0] mem_wd,
   output logic [31:0] d_o
);

   logic [15:0] half;
   logic [31:0] rd;

   always_comb begin
      half = hi ? mem_rd[31:16] : mem_rd[15:0];
      if (BUS16) begin
         mem_wd = {d_i[15:0], d_i[15:0]};
         rd     = {half, half};
      end else begin
         mem_wd = d_i;
         rd     = mem_rd;
      end
      // Undriven (zero) outside the completion cycle so that targets can share D.
      d_o = ready ? rd : 32'h0;
   end

endmodule

// File: rtl/v810_bus_target.sv
// v810_bus_target: V810 external bus responder for one address region.
// Decodes CPU bus cycles, inserts WAIT_STATES T2 cycles, then issues one
// request on a 32-bit word memory port and completes the cycle on MEM_ACK.
//   CLK, RESn, CE   clock, sync active-low reset, global clock enable
//   bus             CPU bus (slave modport): A, D_I, BEn, ST, DAn, MRQn, RW,
//                   BCYSTn in; D_O, READYn, SZRQn out
//   MEM_A/WD/BE/WR  latched word address, write data, active-high BE, write flag
//   MEM_REQ/ACK/RD  request, completion, read data (valid with ACK)
module v810_bus_target
   import v810_bus_pkg::*;
#(
   parameter logic [31:0] BASE        = 32'h0700_0000,
   parameter logic [31:0] MASK        = 32'hFF00_0000,
   parameter int unsigned WAIT_STATES = 0,
   parameter bit          BUS16       = 1'b0
) (
   input  logic        CLK,
   input  logic        RESn,
   input  logic        CE,
   v810_bus_if.slave   bus,
   output logic [29:0] MEM_A,
   output logic [31:0] MEM_WD,
   output logic [3:0]  MEM_BE,
   output logic        MEM_WR,
   output logic        MEM_REQ,
   input  logic        MEM_ACK,
   input  logic [31:0] MEM_RD
);

   localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

   tgt_state_e       state;
   logic [CNT_W-1:0] cnt;
   bus_cyc_t         cyc;
   logic             hit;
   logic             acc_live;
   logic             ready;

   assign hit = ~bus.BCYSTn & ~bus.MRQn & ((bus.A & MASK) == BASE);

   always_ff @(posedge CLK) begin
      if (CE) begin
         if (!RESn) begin
            state <= TS_IDLE;
            cnt   <= '0;
            cyc   <= '0;
         end else begin
            case (state)
               TS_IDLE: begin
                  if (hit) begin
                     cyc   <= '{addr: bus.A[31:2], be: ~bus.BEn, rw: bus.RW, st: bus.ST};
                     cnt   <= WS;
                     state <= (WS != '0) ? TS_WAIT : TS_ACC;
                  end
               end
               TS_WAIT: begin
                  if (bus.DAn) begin
                     state <= TS_IDLE;
                  end else begin
                     cnt <= cnt - 1'b1;
                     if (cnt == CNT_W'(1))
                        state <= TS_ACC;
                  end
               end
               TS_ACC: begin
                  // DAn high: CPU dropped the cycle; ACK is ignored.
                  if (bus.DAn || MEM_ACK)
                     state <= TS_IDLE;
               end
               default: state <= TS_IDLE;
            endcase
         end
      end
   end

   // Request and completion are masked in the cycle an abandon is seen.
   assign acc_live = (state == TS_ACC) & ~bus.DAn;
   assign ready    = acc_live & MEM_ACK;

   assign MEM_REQ    = acc_live;
   assign MEM_A      = cyc.addr;
   assign MEM_BE     = cyc.be;
   assign MEM_WR     = ~cyc.rw;
   assign bus.READYn = ~ready;
   assign bus.SZRQn  = ~(BUS16 & (state != TS_IDLE));

   v810_tgt_lanes #(.BUS16(BUS16)) u_lanes (
      .ready  (ready),
      .hi     (cyc.be[1:0] == 2'b00),
      .d_i    (bus.D_I),
      .mem_rd (MEM_RD),
      .mem_wd (MEM_WD),
      .d_o    (bus.D_O)
   );

   // A[1:0] is covered by BEn; ST is captured only for the shared cycle record.
   logic unused_ok;
   assign unused_ok = ^{bus.A[1:0], cyc.st};

endmodule

// File: tb/tb_v810_bus_target.sv
module tb_v810_bus_target;

   logic        CLK = 1'b0;
   logic        RESn, CE;
   logic [31:0] A, D_I;
   logic [3:0]  BEn;
   logic [1:0]  ST;
   logic        DAn, MRQn, RW, BCYSTn;
   logic        MEM_ACK;
   logic [31:0] MEM_RD;
   int          sel;

   logic [31:0] d_o    [3];
   logic        readyn [3];
   logic        szrqn  [3];
   logic [29:0] mem_a  [3];
   logic [31:0] mem_wd [3];
   logic [3:0]  mem_be [3];
   logic        mem_wr [3];
   logic        mem_req[3];

   int pass = 0;
   int total = 0;

   always #5 CLK = ~CLK;

   // Instance 0: 0 waits, 32-bit. Instance 1: 3 waits. Instance 2: BUS16.
   // Only the instance named by sel sees BCYSTn low.
   for (genvar k = 0; k < 3; k++) begin : g
      v810_bus_if bus ();
      assign bus.A      = A;
      assign bus.D_I    = D_I;
      assign bus.BEn    = BEn;
      assign bus.ST     = ST;
      assign bus.DAn    = DAn;
      assign bus.MRQn   = MRQn;
      assign bus.RW     = RW;
      assign bus.BCYSTn = BCYSTn | (sel != k);
      assign d_o[k]     = bus.D_O;
      assign readyn[k]  = bus.READYn;
      assign szrqn[k]   = bus.SZRQn;

      v810_bus_target #(
         .BASE        (32'h0700_0000),
         .MASK        (32'hFF00_0000),
         .WAIT_STATES ((k == 1) ? 3 : 0),
         .BUS16       ((k == 2) ? 1'b1 : 1'b0)
      ) dut (
         .CLK     (CLK),
         .RESn    (RESn),
         .CE      (CE),
         .bus     (bus.slave),
         .MEM_A   (mem_a[k]),
         .MEM_WD  (mem_wd[k]),
         .MEM_BE  (mem_be[k]),
         .MEM_WR  (mem_wr[k]),
         .MEM_REQ (mem_req[k]),
         .MEM_ACK (MEM_ACK),
         .MEM_RD  (MEM_RD)
      );
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      BCYSTn = 1'b1; MRQn = 1'b1; DAn = 1'b1;
   endtask

   task automatic t1(input logic [31:0] a, input logic [3:0] ben, input logic rw);
      A = a; BEn = ben; RW = rw; ST = 2'b10;
      BCYSTn = 1'b0; MRQn = 1'b0; DAn = 1'b1;
   endtask

   task automatic test_reset();
      RESn = 1'b0; CE = 1'b1; idle();
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({readyn[k], szrqn[k], mem_req[k]} !== 3'b110 || d_o[k] !== 32'h0)
            $display("FAIL reset[%0d]: got rdy/sz/req=%b%b%b d_o=%h expected 110 / 0",
                     k, readyn[k], szrqn[k], mem_req[k], d_o[k]);
         else pass++;
      end
      RESn = 1'b1;
      tick();
   endtask

   task automatic test_word_read();
      sel = 0; MEM_ACK = 1'b1; MEM_RD = 32'hDEAD_BEEF;
      t1(32'h0700_0010, 4'b0000, 1'b1);
      #1;
      total++;
      if (readyn[0] !== 1'b1) $display("FAIL rd_t1_ready: got %b expected 1", readyn[0]); else pass++;
      tick();
      BCYSTn = 1'b1; DAn = 1'b0;
      #1;
      total++;
      if (readyn[0] !== 1'b0) $display("FAIL rd_t2_ready: got %b expected 0", readyn[0]); else pass++;
      total++;
      if (d_o[0] !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h expected deadbeef", d_o[0]); else pass++;
      total++;
      if (mem_a[0] !== 30'h01C0_0004) $display("FAIL rd_addr: got %h expected 01c00004", mem_a[0]); else pass++;
      total++;
      if ({mem_req[0], mem_wr[0], mem_be[0]} !== 6'b10_1111)
         $display("FAIL rd_ctl: got req/wr/be=%b %b %b expected 1 0 1111", mem_req[0], mem_wr[0], mem_be[0]);
      else pass++;
      tick();
      idle();
      #1;
      total++;
      if (readyn[0] !== 1'b1 || mem_req[0] !== 1'b0 || d_o[0] !== 32'h0)
         $display("FAIL rd_after: got rdy=%b req=%b d_o=%h expected 1 0 0", readyn[0], mem_req[0], d_o[0]);
      else pass++;
      tick();
   endtask

   task automatic test_wait_write();
      sel = 1; MEM_ACK = 1'b1;
      t1(32'h0700_0004, 4'b1101, 1'b0);
      tick();
      BCYSTn = 1'b1; DAn = 1'b0; D_I = 32'h0000_5A00;
      for (int c = 1; c <= 4; c++) begin
         #1;
         total++;
         if (c < 4) begin
            if (mem_req[1] !== 1'b0 || readyn[1] !== 1'b1)
               $display("FAIL ws_wait%0d: got req=%b rdy=%b expected 0 1", c, mem_req[1], readyn[1]);
            else pass++;
         end else begin
            if (mem_req[1] !== 1'b1 || readyn[1] !== 1'b0)
               $display("FAIL ws_acc: got req=%b rdy=%b expected 1 0", mem_req[1], readyn[1]);
            else pass++;
            total++;
            if ({mem_be[1], mem_wr[1]} !== 5'b0010_1 || mem_wd[1] !== 32'h0000_5A00 || mem_a[1] !== 30'h01C0_0001)
               $display("FAIL ws_wr: got be=%b wr=%b wd=%h a=%h expected 0010 1 00005a00 01c00001",
                        mem_be[1], mem_wr[1], mem_wd[1], mem_a[1]);
            else pass++;
         end
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_bus16();
      sel = 2; MEM_ACK = 1'b1; MEM_RD = 32'h1234_5678;
      t1(32'h0700_0000, 4'b0000, 1'b1);
      #1;
      total++;
      if (szrqn[2] !== 1'b1) $display("FAIL b16_t1_sz: got %b expected 1", szrqn[2]); else pass++;
      tick();
      BCYSTn = 1'b1; DAn = 1'b0; D_I = 32'hAAAA_BBBB;
      #1;
      total++;
      if (szrqn[2] !== 1'b0 || readyn[2] !== 1'b0)
         $display("FAIL b16_lo_hs: got sz=%b rdy=%b expected 0 0", szrqn[2], readyn[2]);
      else pass++;
      total++;
      if (d_o[2] !== 32'h5678_5678) $display("FAIL b16_lo_data: got %h expected 56785678", d_o[2]); else pass++;
      total++;
      if (mem_wd[2] !== 32'hBBBB_BBBB) $display("FAIL b16_wd: got %h expected bbbbbbbb", mem_wd[2]); else pass++;
      tick();
      t1(32'h0700_0002, 4'b0011, 1'b1);
      tick();
      BCYSTn = 1'b1; DAn = 1'b0;
      #1;
      total++;
      if (d_o[2] !== 32'h1234_1234 || mem_be[2] !== 4'b1100 || szrqn[2] !== 1'b0)
         $display("FAIL b16_hi: got d_o=%h be=%b sz=%b expected 12341234 1100 0", d_o[2], mem_be[2], szrqn[2]);
      else pass++;
      tick();
      idle();
      #1;
      total++;
      if (szrqn[2] !== 1'b1) $display("FAIL b16_idle_sz: got %b expected 1", szrqn[2]); else pass++;
      tick();
   endtask

   task automatic test_nonhit();
      sel = 0; MEM_ACK = 1'b1;
      t1(32'h0500_0000, 4'b0000, 1'b1);
      for (int c = 0; c < 3; c++) begin
         #1;
         total++;
         if ({readyn[0], szrqn[0], mem_req[0]} !== 3'b110)
            $display("FAIL nonhit%0d: got rdy/sz/req=%b%b%b expected 110", c, readyn[0], szrqn[0], mem_req[0]);
         else pass++;
         tick();
         BCYSTn = 1'b1; DAn = 1'b0;
      end
      idle();
      tick();
   endtask

   task automatic test_back_to_back();
      sel = 0; MEM_ACK = 1'b0;
      t1(32'h0700_0020, 4'b0000, 1'b1);
      tick();
      BCYSTn = 1'b1; DAn = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         total++;
         if (readyn[0] !== 1'b1 || mem_req[0] !== 1'b1)
            $display("FAIL stall%0d: got rdy=%b req=%b expected 1 1", c, readyn[0], mem_req[0]);
         else pass++;
         tick();
      end
      MEM_ACK = 1'b1;
      #1;
      total++;
      if (readyn[0] !== 1'b0) $display("FAIL stall_ack: got %b expected 0", readyn[0]); else pass++;
      tick();
      t1(32'h0700_0040, 4'b0000, 1'b1);
      #1;
      total++;
      if (readyn[0] !== 1'b1) $display("FAIL b2b_t1: got %b expected 1", readyn[0]); else pass++;
      tick();
      BCYSTn = 1'b1; DAn = 1'b0;
      #1;
      total++;
      if (readyn[0] !== 1'b0 || mem_a[0] !== 30'h01C0_0010)
         $display("FAIL b2b_t2: got rdy=%b a=%h expected 0 01c00010", readyn[0], mem_a[0]);
      else pass++;
      tick();
      idle();
      tick();
   endtask

   task automatic test_abandon();
      sel = 0; MEM_ACK = 1'b0;
      t1(32'h0700_0030, 4'b0000, 1'b1);
      tick();
      BCYSTn = 1'b1; DAn = 1'b0;
      #1;
      total++;
      if (mem_req[0] !== 1'b1) $display("FAIL abn_req: got %b expected 1", mem_req[0]); else pass++;
      tick();
      DAn = 1'b1; MEM_ACK = 1'b1;
      #1;
      total++;
      if (mem_req[0] !== 1'b0 || readyn[0] !== 1'b1)
         $display("FAIL abn_drop: got req=%b rdy=%b expected 0 1", mem_req[0], readyn[0]);
      else pass++;
      tick();
      DAn = 1'b0;
      #1;
      total++;
      if (mem_req[0] !== 1'b0) $display("FAIL abn_idle: got %b expected 0", mem_req[0]); else pass++;
      idle();
      tick();
   endtask

   task automatic test_ce_freeze();
      sel = 1; MEM_ACK = 1'b1;
      t1(32'h0700_0008, 4'b0000, 1'b1);
      tick();
      BCYSTn = 1'b1; DAn = 1'b0; CE = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      total++;
      if (mem_req[1] !== 1'b0) $display("FAIL ce_frozen: got %b expected 0", mem_req[1]); else pass++;
      CE = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         #1;
         total++;
         if (mem_req[1] !== (c == 4))
            $display("FAIL ce_run%0d: got req=%b expected %b", c, mem_req[1], (c == 4));
         else pass++;
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_reset_mid();
      sel = 1; MEM_ACK = 1'b1;
      t1(32'h0700_0008, 4'b0000, 1'b1);
      tick();
      BCYSTn = 1'b1; DAn = 1'b0;
      tick();
      RESn = 1'b0;
      tick();
      RESn = 1'b1;
      #1;
      total++;
      if ({readyn[1], szrqn[1], mem_req[1]} !== 3'b110 || d_o[1] !== 32'h0)
         $display("FAIL rstmid_out: got rdy/sz/req=%b%b%b d_o=%h expected 110 / 0",
                  readyn[1], szrqn[1], mem_req[1], d_o[1]);
      else pass++;
      for (int c = 0; c < 4; c++) begin
         #1;
         total++;
         if (mem_req[1] !== 1'b0) $display("FAIL rstmid_drop%0d: got req=%b expected 0", c, mem_req[1]); else pass++;
         tick();
      end
      MEM_RD = 32'hCAFE_F00D;
      t1(32'h0700_000C, 4'b0000, 1'b1);
      tick();
      BCYSTn = 1'b1; DAn = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         #1;
         if (c == 4) begin
            total++;
            if (readyn[1] !== 1'b0 || d_o[1] !== 32'hCAFE_F00D || mem_a[1] !== 30'h01C0_0003)
               $display("FAIL rstmid_next: got rdy=%b d_o=%h a=%h expected 0 cafef00d 01c00003",
                        readyn[1], d_o[1], mem_a[1]);
            else pass++;
         end
         tick();
      end
      idle();
      tick();
   endtask

   initial begin
      sel = 0; CE = 1'b1; RESn = 1'b0;
      A = '0; D_I = '0; BEn = 4'hF; ST = '0; RW = 1'b1;
      MEM_ACK = 1'b0; MEM_RD = '0;
      idle();
      test_reset();
      test_word_read();
      test_wait_write();
      test_bus16();
      test_nonhit();
      test_back_to_back();
      test_abandon();
      test_ce_freeze();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule

// File: doc/v810_bus_target.md
# v810_bus_target

Responder for the V810 external bus. It decodes the bus cycles the CPU memory unit initiates and drives READYn, SZRQn and read data back to the CPU. It bridges each selected cycle to a simple 32-bit word-addressed memory port with programmable wait states and optional 16-bit dynamic bus sizing. It sits on the board side of the CPU, one instance per address region; the READYn and SZRQn outputs of all instances are ANDed.

## Interface
- BASE, 32'h0700_0000: region base address.
- MASK, 32'hFF00_0000: decode mask; the cycle hits when (A & MASK) == BASE.
- WAIT_STATES, 0: extra T2 cycles inserted before the memory request, range 0..15.
- BUS16, 0: 1 = present a 16-bit device (assert SZRQn; data only on D[15:0]).
- CLK  in  1  core clock; one clock domain.
- RESn  in  1  reset; synchronous, active-low, sampled on rising CLK with CE high.
- CE  in  1  global clock enable; all state advances only when CE=1.
- A  in  32  CPU address; valid in T1 and T2.
- D_I  in  32  CPU write data; valid in T2.
- D_O  out  32  read data to the CPU.
- BEn  in  4  byte enables, active-low.
- ST  in  2  bus status; latched, not decoded.
- DAn  in  1  data access strobe, low in T2.
- MRQn  in  1  memory request, active-low.
- RW  in  1  1=read, 0=write.
- BCYSTn  in  1  bus cycle start, low in T1.
- READYn  out  1  cycle complete, active-low.
- SZRQn  out  1  16-bit sizing request, active-low.
- MEM_A  out  30  word address, latched A[31:2].
- MEM_WD  out  32  write data.
- MEM_BE  out  4  byte enables, active-high.
- MEM_WR  out  1  1=write.
- MEM_REQ  out  1  access request.
- MEM_ACK  in  1  access done; MEM_RD valid in the same cycle.
- MEM_RD  in  32  read data.

## Operation
- hit = ~BCYSTn & ~MRQn & ((A & MASK) == BASE).
- States (shared enum): TS_IDLE, TS_WAIT, TS_ACC.
- TS_IDLE: on hit, latch A[31:2], ~BEn, RW and ST. Load the wait counter with WAIT_STATES. Go to TS_WAIT if WAIT_STATES>0, else TS_ACC.
- TS_WAIT: decrement the counter each CE cycle; when the counter is 1, go to TS_ACC.
- TS_ACC: MEM_REQ=1. On MEM_ACK: READYn=0 (combinational, same cycle) and go to TS_IDLE. Otherwise stay.
- DAn high while in TS_WAIT or TS_ACC means the CPU abandoned the cycle: return to TS_IDLE with no READYn and no memory request in that cycle.
- MEM_WR = ~latched RW; MEM_BE = latched byte enables; MEM_A = latched address.
- 32-bit mode: MEM_WD = D_I; D_O = MEM_RD when READYn=0, else 0.
- BUS16 mode:
  - hi = (latched BE[1:0] == 0).
  - MEM_WD = {D_I[15:0], D_I[15:0]}.
  - D_O[15:0] = hi ? MEM_RD[31:16] : MEM_RD[15:0], replicated onto D_O[31:16].
  - A word access arrives as two separate bus cycles: the first with A[1]=0, BE=4'b1111; the second with A[1]=1, BE=4'b1100. Each cycle produces its own memory request.
- SZRQn = ~(BUS16 & state != TS_IDLE), so it is stable for the whole data phase.
- Reset values: state TS_IDLE, counter 0, READYn=1, SZRQn=1, MEM_REQ=0, D_O=0. Reset in the middle of a cycle drops it silently.
- A non-hit cycle leaves every output at its idle value, so other targets can respond.

## Timing
- Minimum cycle, with WAIT_STATES=0 and MEM_ACK held high: T1 (hit latched) then T2 (MEM_REQ=1, READYn=0). That is 2 cycles, the CPU's minimum.
- Data-phase length = WAIT_STATES + 1 + (cycles MEM_ACK is held low).
- Back-to-back cycles: the CPU's T1 in the cycle after READYn=0 is taken from TS_IDLE; no lost cycle.
- READYn, SZRQn and D_O are combinational from registered state and MEM_ACK. They are sampled by the CPU at the same CLK edge that ends T2.
- The write to memory occurs in the READYn=0 cycle, using live D_I.
- CE=0 freezes the state; combinational outputs follow their inputs.

## Structure
- Package v810_bus_pkg holds:
  - the target state enum;
  - a localparam for the counter width (4);
  - a shared bus-cycle record (address, byte enables, RW, ST), for later reuse by a bus monitor.
- Optional sub-module v810_tgt_lanes (combinational): 16/32-bit lane steering for MEM_WD and D_O. Everything else is flat.

## Test plan
- Word read, 0 waits, MEM_ACK=1, A=0x0700_0010, MEM_RD=0xDEADBEEF -> READYn low in the 2nd cycle; D_O=0xDEADBEEF; MEM_A=0x01C0_0004.
- Byte write, WAIT_STATES=3, A=0x0700_0004, BEn=4'b1101, D_I=0x0000_5A00 -> MEM_REQ first high in the 4th T2 cycle; MEM_BE=4'b0010; READYn low in the same cycle.
- BUS16 word read, MEM_RD=0x1234_5678 on both cycles -> SZRQn low; 1st cycle D_O[15:0]=0x5678; 2nd cycle (A[1]=1, BEn=4'b0011) D_O[15:0]=0x1234.
- Non-hit cycle, A=0x0500_0000 -> READYn=1, SZRQn=1, MEM_REQ=0 throughout.
- MEM_ACK held low for 5 cycles, then back-to-back T1 -> READYn low only on the ACK cycle; the second cycle is latched with no gap.
- RESn low during TS_WAIT -> next cycle TS_IDLE with every output at its reset value; the following hit completes normally.
